regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the RV32I core, replacing the fixed 2-read/1-write register file. Provides NRD combinational read ports with optional write-to-read bypass, one synchronous write port, a per-register pending-write scoreboard for the decode/hazard logic, and a registered debug view port for board display. x0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- ADDR_W, 5, register address width; register count is NREGS = 2**ADDR_W
- NRD, 2, number of read ports, minimum 1
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- rs  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rs_busy  out  NRD  port i source register has an outstanding allocated write
- rd  in  ADDR_W  write address
- wd  in  XLEN  write data
- writeEnable  in  1  commit wd to rd at the next rising edge
- alloc_en  in  1  mark alloc_rd as pending at the next rising edge
- alloc_rd  in  ADDR_W  register being allocated by an issuing instruction
- view  in  ADDR_W  debug register select
- out  out  XLEN  registered contents of register view

## Operation
- Storage: NREGS-1 registers of XLEN bits (x1..x(NREGS-1)); x0 is not stored.
- Write: at the rising edge with writeEnable=1 and rd!=0, reg[rd] <= wd. rd=0 writes are discarded.
- Read (per port i, combinational): rs_i=0 -> 0; else if BYPASS=1, writeEnable=1 and rd=rs_i -> wd; else reg[rs_i].
- Scoreboard: busy[NREGS-1:1], busy[0] constant 0.
  - alloc_en=1 and alloc_rd!=0: busy[alloc_rd] <= 1.
  - writeEnable=1 and rd!=0: busy[rd] <= 0, unless the same edge also allocates rd; allocation wins (new producer) and busy stays 1.
  - Writes to a non-busy register are legal and leave busy at 0.
- rs_busy[i] = busy[rs_i], except forced 0 when BYPASS=1, writeEnable=1 and rd=rs_i (data available this cycle).
- View: at each rising edge, out <= value register view will hold after that edge (i.e. wd if writeEnable=1 and rd=view!=0, else reg[view]); view=0 -> out <= 0.
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0, out 0; rdata returns 0 for every port during reset; rs_busy all 0. Writes/allocations presented while rst=0 are ignored. Reset mid-operation discards pending allocations.

## Timing
- Read latency: 0 cycles (combinational from rs, rd, wd, writeEnable).
- Write latency: visible on rdata in the same cycle when BYPASS=1, otherwise from the cycle after the edge.
- Scoreboard: alloc visible on rs_busy the cycle after the edge; clear visible after the edge (same cycle if BYPASS=1, per forcing rule).
- out: 1-cycle latency from view change; reflects a write committed on the same edge.
- Multiple read ports may address the same register simultaneously; all return identical data.
- No back-pressure; every request is accepted each cycle.

## Test plan
- Reset: hold rst=0 for 10 cycles, release; read x1..x31 on all ports -> all 0, rs_busy=0, out=0.
- Write/read, BYPASS=1: writeEnable=1, rd=1, wd=100, rs_0=1 -> rdata_0=100 in same cycle; next cycle writeEnable=0, view=1 -> out=100 after one edge; rd=2, wd=200 then view=2 -> out=200.
- x0 protection: writeEnable=1, rd=0, wd=32'hDEADBEEF -> rdata for rs=0 stays 0; out with view=0 stays 0; busy never set by alloc_rd=0.
- Scoreboard: alloc_en=1, alloc_rd=5 -> rs_busy=1 for rs=5 next cycle; write rd=5, wd=7 -> rs_busy=0 in write cycle (BYPASS=1), rdata=7; simultaneous alloc_rd=5 and write rd=5 -> busy stays 1, reg[5] updated.
- BYPASS=0 build: write rd=3, wd=55 with rs_0=3 -> rdata_0 shows old value (0) that cycle, 55 next cycle; NRD=3 all ports reading x3 agree.
- Async reset mid-operation: after writing x4=9 and allocating x6, drive rst=0 between edges -> reg[4]=0, busy[6]=0, out=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with x0 hardwired to zero,
// optional write-to-read bypass, a pending-write scoreboard for hazard
// detection, and a registered debug view port.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rs,
    output logic [NRD*XLEN-1:0]     rdata,
    output logic [NRD-1:0]          rs_busy,
    input  logic [ADDR_W-1:0]       rd,
    input  logic [XLEN-1:0]         wd,
    input  logic                    writeEnable,
    input  logic                    alloc_en,
    input  logic [ADDR_W-1:0]       alloc_rd,
    input  logic [ADDR_W-1:0]       view,
    output logic [XLEN-1:0]         out
);

    localparam int                NREGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] X0     = {ADDR_W{1'b0}};
    localparam logic [XLEN-1:0]   ZERO_D = {XLEN{1'b0}};

    // x0 is never stored; all writes and reads of it are filtered out
    logic [XLEN-1:0]  regs_r [1:NREGS-1];
    logic [NREGS-1:1] busy_r;
    logic [NREGS-1:1] busy_nxt_s;
    logic [XLEN-1:0]  out_r;
    logic             wr_hit_s;
    logic             al_hit_s;

    assign wr_hit_s = writeEnable && (rd != X0);
    assign al_hit_s = alloc_en && (alloc_rd != X0);

    // Register storage: commit write data on the rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k < NREGS; k++) begin
                regs_r[k] <= ZERO_D;
            end
        end else if (wr_hit_s) begin
            regs_r[rd] <= wd;
        end else begin
            regs_r[1] <= regs_r[1];
        end
    end

    // Scoreboard next state: a new allocation wins over a clearing write
    always_comb begin
        busy_nxt_s = busy_r;
        for (int k = 1; k < NREGS; k++) begin
            if (al_hit_s && (alloc_rd == ADDR_W'(k))) begin
                busy_nxt_s[k] = 1'b1;
            end else if (wr_hit_s && (rd == ADDR_W'(k))) begin
                busy_nxt_s[k] = 1'b0;
            end else begin
                busy_nxt_s[k] = busy_r[k];
            end
        end
    end

    // Scoreboard state register; reset drops all pending allocations
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= {(NREGS-1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Debug view: show the value the selected register holds after this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r <= ZERO_D;
        end else if (view == X0) begin
            out_r <= ZERO_D;
        end else if (wr_hit_s && (rd == view)) begin
            out_r <= wd;
        end else begin
            out_r <= regs_r[view];
        end
    end

    assign out = out_r;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              byp_s;
        logic [XLEN-1:0]   data_s;
        logic              busy_s;

        assign addr_s = rs[i*ADDR_W +: ADDR_W];
        assign byp_s  = (BYPASS != 0) && writeEnable && (rd == addr_s);

        // Read port mux: zero for x0/reset, forwarded data, else stored value
        always_comb begin
            data_s = ZERO_D;
            busy_s = 1'b0;
            if (!rst || (addr_s == X0)) begin
                data_s = ZERO_D;
                busy_s = 1'b0;
            end else if (byp_s) begin
                data_s = wd;
                busy_s = 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rdata[i*XLEN +: XLEN] = data_s;
        assign rs_busy[i]            = busy_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing 2-port build and a
// non-bypassing 3-port build share stimulus and one behavioural model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rs_a;
    logic [14:0] rs_b;
    logic [63:0] rdata_a;
    logic [95:0] rdata_b;
    logic [1:0]  busy_a;
    logic [2:0]  busy_b;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        writeEnable;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [4:0]  view;
    logic [31:0] out_a;
    logic [31:0] out_b;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rs(rs_a), .rdata(rdata_a), .rs_busy(busy_a),
        .rd(rd), .wd(wd), .writeEnable(writeEnable), .alloc_en(alloc_en),
        .alloc_rd(alloc_rd), .view(view), .out(out_a)
    );

    regfile_mp #(.XLEN(32), .ADDR_W(5), .NRD(3), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rs(rs_b), .rdata(rdata_b), .rs_busy(busy_b),
        .rd(rd), .wd(wd), .writeEnable(writeEnable), .alloc_en(alloc_en),
        .alloc_rd(alloc_rd), .view(view), .out(out_b)
    );

    typedef struct packed {
        logic [63:0] rda;
        logic [1:0]  bza;
        logic [95:0] rdb;
        logic [2:0]  bzb;
        logic [31:0] outv;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem_m [32];
    bit          busy_m [32];
    logic [31:0] out_m;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (!rst || a == 5'd0) return 32'd0;
        if (byp && writeEnable && rd == a) return wd;
        return mem_m[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a, input bit byp);
        if (!rst || a == 5'd0) return 1'b0;
        if (byp && writeEnable && rd == a) return 1'b0;
        return busy_m[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive, record expectations, then apply edge rules
    task automatic cycle(input logic r, input logic w, input logic [4:0] d,
                         input logic [31:0] data, input logic al,
                         input logic [4:0] ard, input logic [4:0] v,
                         input logic [9:0] ra, input logic [14:0] rb);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r; writeEnable = w; rd = d; wd = data;
        alloc_en = al; alloc_rd = ard; view = v; rs_a = ra; rs_b = rb;
        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                mem_m[i] = 32'd0;
                busy_m[i] = 1'b0;
            end
            out_m = 32'd0;
        end
        e.outv = out_m;
        for (int p = 0; p < 2; p++) begin
            e.rda[p*32 +: 32] = m_read(ra[p*5 +: 5], 1'b1);
            e.bza[p]          = m_busy(ra[p*5 +: 5], 1'b1);
        end
        for (int p = 0; p < 3; p++) begin
            e.rdb[p*32 +: 32] = m_read(rb[p*5 +: 5], 1'b0);
            e.bzb[p]          = m_busy(rb[p*5 +: 5], 1'b0);
        end
        exp_q.push_back(e);
        if (r) begin
            if (v == 5'd0) out_m = 32'd0;
            else if (w && d == v) out_m = data;
            else out_m = mem_m[v];
            if (w && d != 5'd0) begin
                mem_m[d] = data;
                busy_m[d] = 1'b0;
            end
            if (al && ard != 5'd0) busy_m[ard] = 1'b1;
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("a.rdata%0d", p), rdata_a[p*32 +: 32], mon_e.rda[p*32 +: 32]);
                chk($sformatf("a.busy%0d", p), {31'd0, busy_a[p]}, {31'd0, mon_e.bza[p]});
            end
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("b.rdata%0d", p), rdata_b[p*32 +: 32], mon_e.rdb[p*32 +: 32]);
                chk($sformatf("b.busy%0d", p), {31'd0, busy_b[p]}, {31'd0, mon_e.bzb[p]});
            end
            chk("a.out", out_a, mon_e.outv);
            chk("b.out", out_b, mon_e.outv);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0]  a5;
        logic [9:0]  ra;
        logic [14:0] rb;
        rst = 1'b0; writeEnable = 1'b0; rd = 5'd0; wd = 32'd0;
        alloc_en = 1'b0; alloc_rd = 5'd0; view = 5'd0; rs_a = 10'd0; rs_b = 15'd0;
        for (int i = 0; i < 32; i++) begin
            mem_m[i] = 32'd0;
            busy_m[i] = 1'b0;
        end
        out_m = 32'd0;

        // reset held, then every register reads zero on all ports
        repeat (10) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, {2{5'd1}}, {3{5'd1}});
        for (int a = 1; a < 32; a++) begin
            a5 = 5'(a);
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a5, {2{a5}}, {3{a5}});
        end

        // write/read and view latency
        cycle(1'b1, 1'b1, 5'd1, 32'd100, 1'b0, 5'd0, 5'd0, {5'd0, 5'd1}, {3{5'd1}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, {2{5'd1}}, {3{5'd1}});
        cycle(1'b1, 1'b1, 5'd2, 32'd200, 1'b0, 5'd0, 5'd1, {2{5'd2}}, {3{5'd2}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, {2{5'd2}}, {3{5'd2}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, {2{5'd2}}, {3{5'd2}});

        // x0 protection: write and allocate x0
        cycle(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, {2{5'd0}}, {3{5'd0}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, {2{5'd0}}, {3{5'd0}});

        // scoreboard set, clear, and allocate-wins collision
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, {2{5'd5}}, {3{5'd5}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, {2{5'd5}}, {3{5'd5}});
        cycle(1'b1, 1'b1, 5'd5, 32'd7, 1'b0, 5'd0, 5'd5, {2{5'd5}}, {3{5'd5}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, {2{5'd5}}, {3{5'd5}});
        cycle(1'b1, 1'b1, 5'd5, 32'd8, 1'b1, 5'd5, 5'd5, {2{5'd5}}, {3{5'd5}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, {2{5'd5}}, {3{5'd5}});

        // non-bypass build sees old value in the write cycle
        cycle(1'b1, 1'b1, 5'd3, 32'd55, 1'b0, 5'd0, 5'd3, {2{5'd3}}, {3{5'd3}});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, {2{5'd3}}, {3{5'd3}});

        // asynchronous reset between edges
        cycle(1'b1, 1'b1, 5'd4, 32'd9, 1'b1, 5'd6, 5'd4, {5'd6, 5'd4}, {5'd4, 5'd6, 5'd4});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, {5'd6, 5'd4}, {5'd4, 5'd6, 5'd4});
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, {5'd6, 5'd4}, {5'd4, 5'd6, 5'd4});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, {5'd6, 5'd4}, {5'd4, 5'd6, 5'd4});
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, {5'd6, 5'd4}, {5'd4, 5'd6, 5'd4});

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) ra[p*5 +: 5] = 5'($urandom_range(7));
            for (int p = 0; p < 3; p++) rb[p*5 +: 5] = 5'($urandom_range(7));
            cycle(($urandom_range(63) != 0), 1'($urandom_range(1)),
                  5'($urandom_range(7)), $urandom, ($urandom_range(3) == 0),
                  5'($urandom_range(7)), 5'($urandom_range(7)), ra, rb);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
